// File: rtl/tree_pkg.sv
// rtl/tree_pkg.sv - shared tree node format, field helpers and encoder state type
package tree_pkg;

  localparam int IDENTIFIER_SIZE     = 8;
  localparam int NODE_ADDR_SIZE      = 8;
  localparam int MAX_NODES_PER_LEVEL = 4;
  localparam int NUM_MSG_HIERARCHY   = 4;
  localparam int NODE_SIZE           = IDENTIFIER_SIZE + NODE_ADDR_SIZE * (1 + MAX_NODES_PER_LEVEL);

  // Node word: {node_id, parent_addr, child list}, MSB first
  localparam int NODE_ID_MSB     = NODE_SIZE - 1;
  localparam int PARENT_ADDR_MSB = NODE_SIZE - 1 - IDENTIFIER_SIZE;

  typedef logic [NODE_SIZE-1:0] tree_node_t;

  typedef enum logic [1:0] {
    ENC_IDLE  = 2'd0,
    ENC_FETCH = 2'd1,
    ENC_WAIT  = 2'd2,
    ENC_EMIT  = 2'd3
  } tree_enc_state_t;

  function automatic logic [IDENTIFIER_SIZE-1:0] node_get_id(input tree_node_t tree_node);
    return tree_node[NODE_ID_MSB -: IDENTIFIER_SIZE];
  endfunction

  function automatic logic [NODE_ADDR_SIZE-1:0] node_get_parent(input tree_node_t tree_node);
    return tree_node[PARENT_ADDR_MSB -: NODE_ADDR_SIZE];
  endfunction

endpackage

// File: rtl/tree_path_encoder_if.sv
// rtl/tree_path_encoder_if.sv - leaf request, tree memory read and identifier stream bundle
interface tree_path_encoder_if #(
  parameter int IDENTIFIER_SIZE = 8,
  parameter int NODE_ADDR_SIZE  = 8,
  parameter int NODE_SIZE       = 48,
  parameter int LEVEL_W         = 2
);

  logic                       leaf_valid;
  logic                       leaf_ready;
  logic [NODE_ADDR_SIZE-1:0]  leaf_addr;

  logic                       mem_rd_en;
  logic [NODE_ADDR_SIZE-1:0]  mem_rd_addr;
  logic [NODE_SIZE-1:0]       mem_rd_data;

  logic                       id_valid;
  logic                       id_ready;
  logic [IDENTIFIER_SIZE-1:0] id_data;
  logic [LEVEL_W-1:0]         id_level;
  logic                       id_last;

  logic                       err_null;
  logic                       err_depth;

  // master: the encoder; slave: message builder, tree memory and serializer side
  modport master (
    input  leaf_valid, leaf_addr, mem_rd_data, id_ready,
    output leaf_ready, mem_rd_en, mem_rd_addr,
           id_valid, id_data, id_level, id_last, err_null, err_depth
  );

  modport slave (
    output leaf_valid, leaf_addr, mem_rd_data, id_ready,
    input  leaf_ready, mem_rd_en, mem_rd_addr,
           id_valid, id_data, id_level, id_last, err_null, err_depth
  );

endinterface

// File: rtl/tree_id_stack.sv
// rtl/tree_id_stack.sv - identifier register array, write at depth, read at pointer
module tree_id_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  always_comb begin
    stack_d = stack_q;
    if (wr_en) begin
      stack_d[wr_ptr] = wr_data;
    end
  end

  // Contents survive between requests; every path overwrites what it reads
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign rd_data = stack_q[rd_ptr];

endmodule

// File: rtl/tree_path_encoder.sv
// rtl/tree_path_encoder.sv - climbs parent pointers from a leaf, emits root-to-leaf identifiers
module tree_path_encoder
  import tree_pkg::*;
#(
  parameter int IDENTIFIER_SIZE     = tree_pkg::IDENTIFIER_SIZE,
  parameter int NODE_ADDR_SIZE      = tree_pkg::NODE_ADDR_SIZE,
  parameter int MAX_NODES_PER_LEVEL = tree_pkg::MAX_NODES_PER_LEVEL,
  parameter int NUM_MSG_HIERARCHY   = tree_pkg::NUM_MSG_HIERARCHY,
  parameter int NODE_SIZE           = IDENTIFIER_SIZE + NODE_ADDR_SIZE * (1 + MAX_NODES_PER_LEVEL)
) (
  input logic                 clk,
  input logic                 rst,
  tree_path_encoder_if.master bus
);

  localparam int LEVEL_W = $clog2(NUM_MSG_HIERARCHY);
  localparam int PTR_W   = LEVEL_W;
  localparam int DEPTH_W = $clog2(NUM_MSG_HIERARCHY + 1);

  tree_enc_state_t           state_q, state_d;
  logic [NODE_ADDR_SIZE-1:0] cur_addr_q, cur_addr_d;
  logic [DEPTH_W-1:0]        depth_q, depth_d;
  logic [DEPTH_W-1:0]        total_depth_q, total_depth_d;
  logic [PTR_W-1:0]          emit_ptr_q, emit_ptr_d;
  logic                      err_null_q, err_null_d;
  logic                      err_depth_q, err_depth_d;

  logic                       stack_we;
  logic [IDENTIFIER_SIZE-1:0] stack_rd_data;
  logic [IDENTIFIER_SIZE-1:0] node_id;
  logic [NODE_ADDR_SIZE-1:0]  parent_addr;
  logic [DEPTH_W-1:0]         depth_inc;

  assign node_id     = node_get_id(bus.mem_rd_data);
  assign parent_addr = node_get_parent(bus.mem_rd_data);
  assign depth_inc   = depth_q + DEPTH_W'(1);

  tree_id_stack #(
    .DEPTH (NUM_MSG_HIERARCHY),
    .WIDTH (IDENTIFIER_SIZE)
  ) u_stack (
    .clk     (clk),
    .wr_en   (stack_we),
    .wr_ptr  (depth_q[PTR_W-1:0]),
    .wr_data (node_id),
    .rd_ptr  (emit_ptr_q),
    .rd_data (stack_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ENC_IDLE;
      cur_addr_q    <= '0;
      depth_q       <= '0;
      total_depth_q <= '0;
      emit_ptr_q    <= '0;
      err_null_q    <= 1'b0;
      err_depth_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      depth_q       <= depth_d;
      total_depth_q <= total_depth_d;
      emit_ptr_q    <= emit_ptr_d;
      err_null_q    <= err_null_d;
      err_depth_q   <= err_depth_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    depth_d       = depth_q;
    total_depth_d = total_depth_q;
    emit_ptr_d    = emit_ptr_q;
    err_null_d    = 1'b0;
    err_depth_d   = 1'b0;
    stack_we      = 1'b0;
    case (state_q)
      ENC_IDLE: begin
        if (bus.leaf_valid) begin
          if (bus.leaf_addr == '0) begin
            err_null_d = 1'b1;
          end else begin
            cur_addr_d = bus.leaf_addr;
            depth_d    = '0;
            state_d    = ENC_FETCH;
          end
        end
      end
      ENC_FETCH: begin
        state_d = ENC_WAIT;
      end
      ENC_WAIT: begin
        stack_we = 1'b1;
        depth_d  = depth_inc;
        // The entry just written is the level directly below the root
        if (parent_addr == '0) begin
          emit_ptr_d    = depth_q[PTR_W-1:0];
          total_depth_d = depth_inc;
          state_d       = ENC_EMIT;
        end else if (depth_inc == DEPTH_W'(NUM_MSG_HIERARCHY)) begin
          err_depth_d = 1'b1;
          state_d     = ENC_IDLE;
        end else begin
          cur_addr_d = parent_addr;
          state_d    = ENC_FETCH;
        end
      end
      ENC_EMIT: begin
        if (bus.id_ready) begin
          if (emit_ptr_q == '0) begin
            state_d = ENC_IDLE;
          end else begin
            emit_ptr_d = emit_ptr_q - PTR_W'(1);
          end
        end
      end
      default: begin
        state_d = ENC_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.leaf_ready  = (state_q == ENC_IDLE) && !rst;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.id_valid    = 1'b0;
    bus.id_data     = '0;
    bus.id_level    = '0;
    bus.id_last     = 1'b0;
    bus.err_null    = err_null_q;
    bus.err_depth   = err_depth_q;
    if (state_q == ENC_FETCH) begin
      bus.mem_rd_en   = 1'b1;
      bus.mem_rd_addr = cur_addr_q;
    end
    if (state_q == ENC_EMIT) begin
      bus.id_valid = 1'b1;
      bus.id_data  = stack_rd_data;
      bus.id_level = LEVEL_W'(total_depth_q - DEPTH_W'(1)) - emit_ptr_q;
      bus.id_last  = (emit_ptr_q == '0);
    end
  end

endmodule

// File: doc/tree_path_encoder.md
# tree_path_encoder

Transmit-side counterpart of the tree walker. It accepts a leaf node address, climbs the tree memory through parent pointers to the root (null node at address 0), and emits the root-to-leaf identifier path on a valid/ready stream. It sits between the message-build logic, which supplies leaf addresses, and the serializer, which consumes identifiers. It shares the node format and tree memory produced by `tree_pkg`.

## Interface
- `IDENTIFIER_SIZE`, 8, node identifier width
- `NODE_ADDR_SIZE`, 8, tree address width
- `MAX_NODES_PER_LEVEL`, 4, child slots per node; only sets `NODE_SIZE`
- `NUM_MSG_HIERARCHY`, 4, maximum path depth in levels
- `NODE_SIZE`, `IDENTIFIER_SIZE+NODE_ADDR_SIZE*(1+MAX_NODES_PER_LEVEL)`, node word width
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `leaf_valid` in 1: leaf request valid
- `leaf_ready` out 1: block can accept a request
- `leaf_addr` in `NODE_ADDR_SIZE`: leaf node address
- `mem_rd_en` out 1: tree memory read strobe
- `mem_rd_addr` out `NODE_ADDR_SIZE`: read address
- `mem_rd_data` in `NODE_SIZE`: node word, valid 1 cycle after `mem_rd_en`
- `id_valid` out 1: identifier valid
- `id_ready` in 1: downstream accepts the identifier
- `id_data` out `IDENTIFIER_SIZE`: identifier
- `id_level` out `$clog2(NUM_MSG_HIERARCHY)`: level of this identifier, 0 = first level below the root
- `id_last` out 1: leaf identifier, ends the path
- `err_null` out 1: one-cycle pulse, leaf_addr was 0
- `err_depth` out 1: one-cycle pulse, root not reached within `NUM_MSG_HIERARCHY` levels

## Operation
- Node word fields:
  - node_id = `[NODE_SIZE-1 -: IDENTIFIER_SIZE]`
  - parent_addr = next `NODE_ADDR_SIZE` bits
  - child list = remaining LSBs, ignored by this block
- FSM states: IDLE, FETCH, WAIT, EMIT.
- **IDLE**
  - `leaf_ready`=1.
  - On `leaf_valid`&&`leaf_ready` with `leaf_addr`==0: pulse `err_null`, stay in IDLE.
  - Otherwise: cur_addr<=`leaf_addr`, depth<=0, go to FETCH.
- **FETCH**
  - `mem_rd_en`=1, `mem_rd_addr`=cur_addr; go to WAIT.
- **WAIT**
  - Capture stack[depth]<=node_id and depth<=depth+1.
  - If parent_addr==0: go to EMIT with emit_ptr=depth (the just-written entry is the topmost level).
  - Else if depth+1==`NUM_MSG_HIERARCHY`: pulse `err_depth`, go to IDLE, emit nothing.
  - Else: cur_addr<=parent_addr, go to FETCH.
- **EMIT**
  - `id_valid`=1, `id_data`=stack[emit_ptr], `id_level`=total_depth-1-emit_ptr, `id_last`=(emit_ptr==0).
  - On `id_valid`&&`id_ready`: if `id_last`, go to IDLE; else emit_ptr<=emit_ptr-1.
- Stack is `NUM_MSG_HIERARCHY` x `IDENTIFIER_SIZE` registers; it is not cleared between requests.
- `leaf_ready`=0 in every state except IDLE; requests are never queued.

## Timing
- Reset values: state=IDLE; `leaf_ready`, `mem_rd_en`, `id_valid`, `id_last`, `err_null`, `err_depth` = 0; `mem_rd_addr`, `id_data`, `id_level` = 0.
- `leaf_ready` is 0 while `rst`=1.
- Path of D levels: request accepted at cycle t → first `id_valid` at t+1+2D.
- With `id_ready` held high: one identifier per cycle, D beats total.
- After the `id_last` handshake, `leaf_ready`=1 on the next cycle.
- Error pulses are exactly 1 cycle: `err_null` in the cycle after the accept; `err_depth` in the cycle after the last WAIT. `leaf_ready` returns in that same cycle.
- `id_valid`, `id_data`, `id_level` and `id_last` stay stable while `id_ready`=0.
- `rst` mid-walk or mid-emit: next cycle is IDLE and all outputs are at reset values. No partial path resumes. A memory read in flight is discarded.
- The memory read port is combinational-address, registered-data, with fixed 1-cycle latency and no backpressure.

## Structure
- Add to `tree_pkg`:
  - `NODE_SIZE`
  - field offset localparams `NODE_ID_MSB` and `PARENT_ADDR_MSB`
  - functions `node_get_id(tree_node)` and `node_get_parent(tree_node)`, shared with the tree walker
  - FSM state enum `tree_enc_state_t`
- Sub-module `tree_id_stack`: register array with write-at-depth and read-at-pointer, reused by the walker's path buffer.

## Test plan
- Single-level path: node 5 = {id 0x11, parent 0}, leaf_addr=5 → one beat `id_data`=0x11, `id_level`=0, `id_last`=1, 3 cycles after accept.
- Three-level path: 7→{0x33, par 4}, 4→{0x22, par 2}, 2→{0x11, par 0} → beats 0x11/L0, 0x22/L1, 0x33/L2 with `id_last` on 0x33; first `id_valid` 7 cycles after accept.
- Backpressure: repeat the three-level case with `id_ready` toggling 0,0,1,0,1,1 → no beat dropped or duplicated, outputs stable while stalled.
- Null and loop errors: leaf_addr=0 → `err_null` pulse, no `mem_rd_en`. Node 3 = {0x44, par 3} with `NUM_MSG_HIERARCHY`=4 → 4 reads, then an `err_depth` pulse and no `id_valid`.
- Reset mid-emit: assert `rst` after the 2nd beat of the three-level case → `id_valid`=0 next cycle; a new request for leaf 5 then emits only 0x11.
